// File: rtl/add_pkg.sv
//------------------------------------------------------------------------------
// Module   : add_pkg
// Brief    : Shared state encoding and nibble width for the serial adder block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package add_pkg;

   localparam int NIB_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage : add_pkg

`default_nettype wire

// File: rtl/nibble_adder.sv
//------------------------------------------------------------------------------
// Module   : nibble_adder
// Brief    : 4-bit ripple-carry adder built from full-adder cells.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibble_adder
   import add_pkg::*;
(
   input  logic             ci,
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   output logic [NIB_W-1:0] s,
   output logic             co
);

   logic [NIB_W:0] w_c;

   assign w_c[0] = ci;

   genvar i;
   generate
      for (i = 0; i < NIB_W; i++) begin : g_fa
         assign s[i]     = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign co = w_c[NIB_W];

endmodule : nibble_adder

`default_nettype wire

// File: rtl/nibble_add_sched.sv
//------------------------------------------------------------------------------
// Module   : nibble_add_sched
// Brief    : Round-robin shared serial adder, one nibble per cycle, valid/ready result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibble_add_sched
   import add_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_ci,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_ci,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_co,
   output logic             res_id,
   input  logic             res_ready,
   output logic             busy
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIB - 1);

   logic [1:0]       r_state;
   logic             r_prio;
   logic             r_carry;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_co;
   logic             r_id;

   logic             w_idle;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_accept;
   logic [NIB_W-1:0] w_a_nib;
   logic [NIB_W-1:0] w_b_nib;
   logic [NIB_W-1:0] w_s;
   logic             w_co;

   // A lone requester wins regardless of prio; prio only breaks ties.
   assign w_idle     = (r_state == ST_IDLE);
   assign w_grant0   = req0_valid & (~req1_valid | ~r_prio);
   assign w_grant1   = req1_valid & (~req0_valid |  r_prio);
   assign req0_ready = w_idle & w_grant0 & ~rst;
   assign req1_ready = w_idle & w_grant1 & ~rst;
   assign w_accept   = req0_ready | req1_ready;

   always_comb begin
      w_a_nib = '0;
      w_b_nib = '0;
      for (int k = 0; k < NIB; k++) begin
         if (r_count == k[CNT_W-1:0]) begin
            w_a_nib = r_a[k*NIB_W +: NIB_W];
            w_b_nib = r_b[k*NIB_W +: NIB_W];
         end
      end
   end

   nibble_adder u_adder (
      .ci (r_carry),
      .a  (w_a_nib),
      .b  (w_b_nib),
      .s  (w_s),
      .co (w_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_prio  <= 1'b0;
         r_carry <= 1'b0;
         r_count <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_co    <= 1'b0;
         r_id    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a     <= req1_ready ? req1_a  : req0_a;
                  r_b     <= req1_ready ? req1_b  : req0_b;
                  r_carry <= req1_ready ? req1_ci : req0_ci;
                  r_id    <= req1_ready;
                  r_count <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int k = 0; k < NIB; k++) begin
                  if (r_count == k[CNT_W-1:0]) begin
                     r_sum[k*NIB_W +: NIB_W] <= w_s;
                  end
               end
               r_carry <= w_co;
               r_count <= r_count + 1'b1;
               if (r_count == C_LAST) begin
                  r_co    <= w_co;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  r_prio  <= ~r_id;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign res_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign res_sum   = r_sum;
   assign res_co    = r_co;
   assign res_id    = r_id;

endmodule : nibble_add_sched

`default_nettype wire
